// File: rtl/lottery_ticket_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : lottery_ticket_tx_if
// Brief    : Bundles the host request/result signals and the lottery-side
//            bet-entry signals of the ticket transmitter.
//            master = transmitter view, slave = host/lottery view.
// Revision : 1.0  initial release
// ============================================================================
interface lottery_ticket_tx_if;
    // Host request
    logic       start;
    logic [4:0] num0;
    logic [4:0] num1;
    logic [4:0] num2;
    logic [4:0] num3;
    // Lottery status and verdict
    logic       sysrdy;
    logic       rd_err;
    logic       winner;
    logic       not_a_win;
    logic [2:0] eur100;
    logic [3:0] eur010;
    logic [3:0] eur001;
    // Lottery-facing outputs
    logic [4:0] n_out;
    logic       scan_out;
    // Host-facing results
    logic       busy;
    logic       done;
    logic       won;
    logic       lost;
    logic       err;
    logic [2:0] prize100;
    logic [3:0] prize010;
    logic [3:0] prize001;
    logic [2:0] retries;

    modport master (
        input  start, num0, num1, num2, num3,
        input  sysrdy, rd_err, winner, not_a_win, eur100, eur010, eur001,
        output n_out, scan_out, busy, done, won, lost, err,
        output prize100, prize010, prize001, retries
    );

    modport slave (
        output start, num0, num1, num2, num3,
        output sysrdy, rd_err, winner, not_a_win, eur100, eur010, eur001,
        input  n_out, scan_out, busy, done, won, lost, err,
        input  prize100, prize010, prize001, retries
    );
endinterface
`default_nettype wire

// File: rtl/lottery_ticket_tx.sv
`default_nettype none
// ============================================================================
// Module   : lottery_ticket_tx
// Brief    : Lottery bet-entry transmitter. Latches a four-number ticket,
//            waits for the lottery to be ready, strobes each number out with
//            setup/high/gap timing, re-sends on read error, then captures the
//            win/no-win verdict and BCD prize for the host.
// Options  : LOTTERY_TX_RANGE_CHECK_EN - reject tickets containing a 0.
// Revision : 1.0  initial release
// ============================================================================
module lottery_ticket_tx #(
    parameter int SETUP_CYC   = 2,
    parameter int SCAN_HIGH   = 2,
    parameter int GAP_CYC     = 2,
    parameter int MAX_RETRY   = 2,
    parameter int RES_TIMEOUT = 255
) (
    input wire                  clk,
    input wire                  reset,
    lottery_ticket_tx_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_SETUP    = 3'd2,
        S_STROBE   = 3'd3,
        S_GAP      = 3'd4,
        S_WAIT_RES = 3'd5,
        S_DONE     = 3'd6,
        S_FAIL     = 3'd7
    } state_t;

    state_t     state_q;
    logic [15:0] cnt_q;       // phase length counter, also the verdict timeout
    logic [1:0]  idx_q;       // which ticket number is on the wire
    logic [4:0]  num_q [4];
    logic [4:0]  n_out_q;
    logic        scan_q;
    logic        busy_q;
    logic        done_q;
    logic        won_q;
    logic        lost_q;
    logic        err_q;
    logic [2:0]  p100_q;
    logic [3:0]  p010_q;
    logic [3:0]  p001_q;
    logic [2:0]  retries_q;

    logic range_bad;
    logic setup_last;
    logic strobe_last;
    logic gap_last;
    logic res_last;

`ifdef LOTTERY_TX_RANGE_CHECK_EN
    assign range_bad = (bus.num0 == 5'd0) || (bus.num1 == 5'd0) ||
                       (bus.num2 == 5'd0) || (bus.num3 == 5'd0);
`else
    assign range_bad = 1'b0;
`endif

    assign setup_last  = (cnt_q == 16'(SETUP_CYC - 1));
    assign strobe_last = (cnt_q == 16'(SCAN_HIGH - 1));
    assign gap_last    = (cnt_q == 16'(GAP_CYC - 1));
    assign res_last    = (cnt_q == 16'(RES_TIMEOUT - 1));

    // Ticket sequencer; every output is registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            for (int i = 0; i < 4; i++) num_q[i] <= '0;
            n_out_q   <= '0;
            scan_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            won_q     <= 1'b0;
            lost_q    <= 1'b0;
            err_q     <= 1'b0;
            p100_q    <= '0;
            p010_q    <= '0;
            p001_q    <= '0;
            retries_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        num_q[0]  <= bus.num0;
                        num_q[1]  <= bus.num1;
                        num_q[2]  <= bus.num2;
                        num_q[3]  <= bus.num3;
                        won_q     <= 1'b0;
                        lost_q    <= 1'b0;
                        p100_q    <= '0;
                        p010_q    <= '0;
                        p001_q    <= '0;
                        retries_q <= '0;
                        cnt_q     <= '0;
                        idx_q     <= '0;
                        busy_q    <= 1'b1;
                        if (range_bad) begin
                            state_q <= S_FAIL;
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_WAIT_RDY;
                            err_q   <= 1'b0;
                        end
                    end
                end

                S_WAIT_RDY: begin
                    if (bus.sysrdy) begin
                        state_q <= S_SETUP;
                        idx_q   <= '0;
                        cnt_q   <= '0;
                        n_out_q <= num_q[0];
                    end
                end

                S_SETUP: begin
                    if (setup_last) begin
                        state_q <= S_STROBE;
                        cnt_q   <= '0;
                        scan_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                S_STROBE: begin
                    if (strobe_last) begin
                        state_q <= S_GAP;
                        cnt_q   <= '0;
                        scan_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                S_GAP: begin
                    // A read error anywhere in the gap throws the whole ticket away.
                    if (bus.rd_err) begin
                        cnt_q   <= '0;
                        n_out_q <= '0;
                        if (retries_q < 3'(MAX_RETRY)) begin
                            retries_q <= retries_q + 3'd1;
                            state_q   <= S_WAIT_RDY;
                        end else begin
                            state_q <= S_FAIL;
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                        end
                    end else if (gap_last) begin
                        cnt_q <= '0;
                        if (idx_q == 2'd3) begin
                            state_q <= S_WAIT_RES;
                            n_out_q <= '0;
                        end else begin
                            state_q <= S_SETUP;
                            idx_q   <= idx_q + 2'd1;
                            n_out_q <= num_q[idx_q + 2'd1];
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                S_WAIT_RES: begin
                    // A verdict on the last timeout cycle still wins over the timeout.
                    if (bus.winner && bus.not_a_win) begin
                        state_q <= S_FAIL;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                    end else if (bus.winner) begin
                        state_q <= S_DONE;
                        won_q   <= 1'b1;
                        p100_q  <= bus.eur100;
                        p010_q  <= bus.eur010;
                        p001_q  <= bus.eur001;
                        done_q  <= 1'b1;
                    end else if (bus.not_a_win) begin
                        state_q <= S_DONE;
                        lost_q  <= 1'b1;
                        p100_q  <= '0;
                        p010_q  <= '0;
                        p001_q  <= '0;
                        done_q  <= 1'b1;
                    end else if (res_last) begin
                        state_q <= S_FAIL;
                        err_q   <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end

                S_DONE, S_FAIL: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    cnt_q   <= '0;
                end

                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    scan_q  <= 1'b0;
                    n_out_q <= '0;
                end
            endcase
        end
    end

    assign bus.n_out    = n_out_q;
    assign bus.scan_out = scan_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.won      = won_q;
    assign bus.lost     = lost_q;
    assign bus.err      = err_q;
    assign bus.prize100 = p100_q;
    assign bus.prize010 = p010_q;
    assign bus.prize001 = p001_q;
    assign bus.retries  = retries_q;

endmodule
`default_nettype wire

// File: doc/lottery_ticket_tx.md
# lottery_ticket_tx

Transmitter end of the lottery bet-entry interface. It accepts a four-number ticket from a host and waits for the lottery to signal system ready. It then presents each number on the lottery's 5-bit number input with a timed scan strobe, retrying when the lottery reports a read error. Finally it captures the lottery's win/no-win verdict and BCD prize, and reports them back to the host.

## Interface
Parameters:
- SETUP_CYC, 2: cycles `n_out` is held stable before `scan_out` rises (≥1)
- SCAN_HIGH, 2: cycles `scan_out` stays high (≥1)
- GAP_CYC, 2: cycles `scan_out` stays low after each strobe; `rd_err` monitor window (≥1)
- MAX_RETRY, 2: ticket re-sends allowed after `rd_err` (0..7)
- RES_TIMEOUT, 255: cycles to wait for a verdict (1..65535)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  host request; sampled only in IDLE
- num0..num3  in  5 each  ticket numbers; latched on accepted start
- sysrdy  in  1  lottery system ready
- rd_err  in  1  lottery read error
- winner, not_a_win  in  1 each  lottery verdict
- eur100 in 3; eur010, eur001 in 4 each  lottery BCD prize
- n_out  out  5  number presented to lottery
- scan_out  out  1  scan strobe to lottery
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on completion (success or fail)
- won, lost, err  out  1 each  result flags, held until next accepted start
- prize100 out 3; prize010, prize001 out 4 each  captured prize, held
- retries  out  3  re-sends used for the current ticket

## Operation
- States: IDLE, WAIT_RDY, SETUP, STROBE, GAP, WAIT_RES, DONE, FAIL.
- IDLE: `start`=1 latches num0..3, clears won/lost/err/prize/retries, and goes to WAIT_RDY. `start` is ignored outside IDLE.
- WAIT_RDY: wait indefinitely for `sysrdy`=1, then go to SETUP with index=0.
- SETUP: `n_out`=num[index] for SETUP_CYC cycles, `scan_out`=0, then STROBE.
- STROBE: `scan_out`=1 for SCAN_HIGH cycles, `n_out` held, then GAP.
- GAP: `scan_out`=0 for GAP_CYC cycles, `n_out` held.
  - `rd_err`=1 on any GAP cycle aborts the ticket. If retries<MAX_RETRY, increment retries and return to WAIT_RDY with index=0. Otherwise go to FAIL.
  - At the end of GAP without error: if index<3, increment index and go to SETUP; if index=3, go to WAIT_RES.
- `rd_err` outside GAP is ignored.
- WAIT_RES: the timeout counter starts at 0.
  - winner=1 and not_a_win=0: capture eur100/eur010/eur001 that cycle, set won, go to DONE.
  - not_a_win=1 and winner=0: prize=0, set lost, go to DONE.
  - Both high: FAIL.
  - Counter reaching RES_TIMEOUT: FAIL.
- DONE: `done`=1 for one cycle, then IDLE.
- FAIL: set err, `done`=1 for one cycle, then IDLE.
- `n_out` is 0 in IDLE, WAIT_RDY, WAIT_RES, DONE and FAIL.
- `sysrdy` dropping mid-ticket is ignored; only `rd_err` aborts.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0. A reset mid-ticket forces `scan_out`=0 at the following edge.
- Start to first SETUP cycle: 2 cycles if `sysrdy` is already high.
- Per number: SETUP_CYC+SCAN_HIGH+GAP_CYC cycles; 6 with defaults, 24 for a full ticket.
- Verdict to `done`: 1 cycle. Prize and flags are valid in the same cycle as `done` and held afterwards.
- `scan_out` is registered and glitch-free. `n_out` never changes while `scan_out`=1 or during GAP.

## Configuration
- LOTTERY_TX_RANGE_CHECK_EN defined: on an accepted start, any latched number equal to 0 goes straight to FAIL. err=1, `done` is pulsed after 1 cycle, and no strobe is issued.
- LOTTERY_TX_RANGE_CHECK_EN undefined: no check; a 0 is transmitted like any other value.

## Test plan
- Nominal win: num=3,7,12,31, sysrdy=1, winner after 10 cycles with eur=1/2/5. Expect 4 strobes of 2 cycles each, carrying n_out 3,7,12,31 in order; then done, won=1, prize 1/2/5, retries=0.
- Loss: not_a_win=1 after the ticket. Expect lost=1, prize 0/0/0, done on the next cycle.
- Retry: rd_err pulsed in the GAP after the 2nd number. Expect a restart from number 0, retries=1, then success. With rd_err on every ticket and MAX_RETRY=2, expect err=1 after 3 sends.
- Timeout and conflict:
  - No verdict for 255 cycles: err=1.
  - winner and not_a_win asserted together: err=1.
- Reset mid-STROBE: scan_out=0 and busy=0 the next cycle. A new start behaves nominally.
- Macro: with LOTTERY_TX_RANGE_CHECK_EN defined and num1=0, expect err=1 and no scan_out activity. With the macro undefined, expect n_out=0 to be transmitted.
